updown_counter: RTL and testbench

//  Parametrised up/down counter: next generation of the free-running 32-bit counter.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_prescaler.sv | 42 ++++
 rtl/updown_counter.sv | 98 +++++++++
 tb/tb_updown_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the updown_counter family.
package counter_pkg;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam logic SAT_WRAP = 1'b0;
    localparam logic SAT_ON   = 1'b1;

    // $clog2 that never returns 0, so a 1-step prescaler still gets a legal 1-bit register.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step divider for updown_counter: pulses tick once every PRESCALE enabled cycles.
// Only built when UPDOWN_COUNTER_PRESCALE_EN is defined.
`ifdef UPDOWN_COUNTER_PRESCALE_EN
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick = en && (pre_q == LAST);

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule
`endif

// File: rtl/updown_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate, tc pulse and sticky ovf.
// Optional step prescaler enabled by defining UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
    parameter int unsigned       PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    // Load also restarts the step period.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr | load),
        .tick  (tick)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign tick = 1'b1;
`endif

    // Bounds are checked before the +/-1, so the adder never rolls over on its own.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en && tick) begin
            case (dir)
                DIR_UP: begin
                    if (count_q == MAX_VAL) begin
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                        count_d = (sat == SAT_WRAP) ? '0 : MAX_VAL;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                DIR_DOWN: begin
                    if (count_q == '0) begin
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                        count_d = (sat == SAT_ON) ? '0 : MAX_VAL;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed scoreboard bench for updown_counter (WIDTH=4, MAX_VAL=9, PRESCALE=4).
module tb_updown_counter;

    localparam int unsigned W   = 4;
    localparam int unsigned MAX = 9;
    localparam int unsigned PRE = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, dir = 1'b0, sat = 1'b0, load = 1'b0, clr = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         tc, ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] count;
        logic         tc;
        logic         ovf;
        string        tag;
    } exp_t;

    exp_t sb[$];

    int unsigned m_count = 0;
    logic        m_tc = 1'b0;
    logic        m_ovf = 1'b0;
    int unsigned m_pre = 0;

    updown_counter #(
        .WIDTH    (W),
        .MAX_VAL  (4'd9),
        .PRESCALE (PRE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .clr      (clr),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_tc    = 1'b0;
        m_ovf   = 1'b0;
        m_pre   = 0;
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input logic e, input logic d, input logic s, input logic l,
                        input logic [W-1:0] lv, input logic c, input string tag);
        exp_t x;
        bit   tick;
        en = e; dir = d; sat = s; load = l; load_val = lv; clr = c;
        if (c) begin
            model_reset();
        end else if (l) begin
            m_count = (lv > MAX) ? MAX : lv;
            m_tc    = 1'b0;
            m_pre   = 0;
        end else begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
            tick = e && (m_pre == PRE - 1);
            if (e) m_pre = tick ? 0 : m_pre + 1;
`else
            tick = 1'b1;
`endif
            m_tc = 1'b0;
            if (e && tick) begin
                if (d) begin
                    if (m_count == MAX) begin
                        m_tc = 1'b1; m_ovf = 1'b1; m_count = s ? MAX : 0;
                    end else m_count = m_count + 1;
                end else begin
                    if (m_count == 0) begin
                        m_tc = 1'b1; m_ovf = 1'b1; m_count = s ? 0 : MAX;
                    end else m_count = m_count - 1;
                end
            end
        end
        x.count = m_count[W-1:0];
        x.tc    = m_tc;
        x.ovf   = m_ovf;
        x.tag   = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({x.tag, "_count"}, 32'(count), 32'(x.count));
        check({x.tag, "_tc"}, 32'(tc), 32'(x.tc));
        check({x.tag, "_ovf"}, 32'(ovf), 32'(x.ovf));
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_count", 32'(count), 0);
        check("rst_tc", 32'(tc), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: wrap counting up through MAX_VAL
        for (int i = 1; i <= 11; i++) begin
            step(1, 1, 0, 0, 0, 0, "t1_up");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
            check("t1_direct_count", 32'(count), 32'(i % 10));
            check("t1_direct_tc", 32'(tc), (i == 10) ? 1 : 0);
`endif
        end

        // 2: saturate at zero while counting down
        step(0, 0, 1, 0, 0, 1, "t2_clr");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, "t2_satdn");
`ifndef UPDOWN_COUNTER_PRESCALE_EN
        check("t2_direct_ovf", 32'(ovf), 1);
        check("t2_direct_tc", 32'(tc), 1);
`endif

        // 3: load beats step; oversized load clamps to MAX_VAL
        step(1, 1, 0, 1, 4'd5, 0, "t3_load5");
        check("t3_direct_5", 32'(count), 5);
        step(1, 1, 0, 1, 4'd12, 0, "t3_load12");
        check("t3_direct_9", 32'(count), 9);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0, 0, "t3_satup");
        step(1, 0, 1, 0, 0, 0, "t3_down");
        step(1, 1, 0, 1, 4'd9, 0, "t3_load9");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, "t3_wrap");

        // 4: clear beats load and drops ovf
        step(1, 1, 0, 1, 4'd7, 1, "t4_clrload");
        check("t4_direct_ovf", 32'(ovf), 0);

        // 5: async reset between edges with count=7, ovf=1
        step(1, 0, 0, 0, 0, 0, "t5_underflow");
        step(0, 1, 0, 1, 4'd7, 0, "t5_load7");
        check("t5_pre_ovf", 32'(ovf), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_count", 32'(count), 0);
        check("t5_async_tc", 32'(tc), 0);
        check("t5_async_ovf", 32'(ovf), 0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // 6: prescaled stepping and stretch by en=0
        for (int i = 1; i <= 4; i++) begin
            step(1, 1, 0, 0, 0, 0, "t6_run");
`ifdef UPDOWN_COUNTER_PRESCALE_EN
            check("t6_direct", 32'(count), (i == 4) ? 1 : 0);
`endif
        end
        step(1, 1, 0, 0, 0, 0, "t6_a");
        step(0, 1, 0, 0, 0, 0, "t6_hold0");
        step(0, 1, 0, 0, 0, 0, "t6_hold1");
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 0, 0, 0, 0, "t6_b");
`ifdef UPDOWN_COUNTER_PRESCALE_EN
            check("t6_stretch", 32'(count), (i == 3) ? 2 : 1);
`endif
        end

        if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
